// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - Y86-64 write-back register file with retire tracking
// Commits valE/valM from one retiring instruction per cycle; two bypassed combinational read ports.
module writeback_regfile #(
  parameter int NREGS = 15,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_valid_i,
  input  logic [3:0]       icode_i,
  input  logic [3:0]       dst_e_i,
  input  logic [3:0]       dst_m_i,
  input  logic [63:0]      val_e_i,
  input  logic [63:0]      val_m_i,
  input  logic [3:0]       src_a_i,
  input  logic [3:0]       src_b_i,
  output logic [63:0]      val_a_o,
  output logic [63:0]      val_b_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] RNONE = 4'hf;

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [63:0]      regs_q [NREGS];
  logic [63:0]      regs_d [NREGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit, wr_en, we_e, we_m;

  function automatic logic id_ok(input logic [3:0] id);
    return (id != RNONE) && (int'(id) < NREGS);
  endfunction

  // A retiring HALT is counted but writes nothing.
  always_comb begin
    commit = wb_valid_i && (state_q == RUN);
    wr_en  = commit && (icode_i != IHALT);
    we_e   = wr_en && id_ok(dst_e_i);
    we_m   = wr_en && id_ok(dst_m_i);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (icode_i == IHALT) state_d = HALTED;
    end
  end

  // valM is applied last so it wins a dstE==dstM collision.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we_e && (dst_e_i == 4'(i))) regs_d[i] = val_e_i;
      if (we_m && (dst_m_i == 4'(i))) regs_d[i] = val_m_i;
    end
  end

  // Reading the next-state array gives the same-cycle write-through bypass.
  assign val_a_o       = id_ok(src_a_i) ? regs_d[src_a_i] : 64'd0;
  assign val_b_o       = id_ok(src_b_i) ? regs_d[src_b_i] : 64'd0;
  assign halted_o      = (state_q == HALTED);
  assign retired_cnt_o = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 64'(i);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule
